regfile_wb_arbiter: RTL and testbench

//  Shares the register file's single write port (waddr/wdata/we) between two writeback requesters:

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_wb_hold_slot.sv | 46 ++++
 rtl/regfile_wb_arbiter.sv | 151 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths, occupancy encoding and writeback payload for the regfile writeback arbiter.
package regfile_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_BOTH  = 2'd2
  } occ_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_hold_slot.sv
// One-entry writeback hold buffer: accepts on valid&ready, frees when granted or when it holds an r0 write.
module wb_hold_slot
  import regfile_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    i_valid,
  input  wb_req_t i_req,
  input  logic    i_grant,
  output logic    o_ready,
  output logic    o_accept,
  output logic    o_drain,
  output logic    o_held,
  output wb_req_t o_entry
);

  logic    r_held;
  wb_req_t r_entry;
  logic    w_drain;
  logic    w_ready;
  logic    w_accept;

  // r0 writes are absorbed: the entry leaves without ever being granted
  assign w_drain  = i_grant | (r_held & (r_entry.addr == REG_ZERO));
  assign w_ready  = ~r_held | w_drain;
  assign w_accept = i_valid & w_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_held  <= 1'b0;
      r_entry <= '0;
    end else if (w_accept) begin
      r_held  <= 1'b1;
      r_entry <= i_req;
    end else if (w_drain) begin
      r_held  <= 1'b0;
    end
  end

  assign o_ready  = w_ready;
  assign o_accept = w_accept;
  assign o_drain  = w_drain;
  assign o_held   = r_held;
  assign o_entry  = r_entry;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the regfile write port between ALU (port 0) and MEM (port 1) writebacks, oldest first.
// Optional REGFILE_WB_BYPASS_EN adds read ports that forward the youngest held write.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
`ifdef REGFILE_WB_BYPASS_EN
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
`endif
  output logic              busy
);

  occ_e    r_state;
  occ_e    w_state_nxt;
  logic    r_old1;
  logic    r_rr;
  logic [1:0] w_valid;
  logic [1:0] w_ready;
  logic [1:0] w_accept;
  logic [1:0] w_drain;
  logic [1:0] w_held;
  logic [1:0] w_zero;
  logic [1:0] w_want;
  logic [1:0] w_grant;
  logic [1:0] w_held_nxt;
  wb_req_t w_entry0;
  wb_req_t w_entry1;

  assign w_valid = {req1_valid, req0_valid};

  wb_hold_slot u_slot0 (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (req0_valid),
    .i_req    ('{addr: req0_addr, data: req0_data}),
    .i_grant  (w_grant[0]),
    .o_ready  (w_ready[0]),
    .o_accept (w_accept[0]),
    .o_drain  (w_drain[0]),
    .o_held   (w_held[0]),
    .o_entry  (w_entry0)
  );

  wb_hold_slot u_slot1 (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (req1_valid),
    .i_req    ('{addr: req1_addr, data: req1_data}),
    .i_grant  (w_grant[1]),
    .o_ready  (w_ready[1]),
    .o_accept (w_accept[1]),
    .o_drain  (w_drain[1]),
    .o_held   (w_held[1]),
    .o_entry  (w_entry1)
  );

  assign w_zero[0] = w_held[0] & (w_entry0.addr == REG_ZERO);
  assign w_zero[1] = w_held[1] & (w_entry1.addr == REG_ZERO);
  assign w_want    = w_held & ~w_zero;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= OCC_EMPTY;
    else      r_state <= w_state_nxt;
  end

  // Next occupancy is rebuilt from slot registers here so the grant never loops back through the slots
  always_comb begin
    w_grant     = 2'b00;
    w_held_nxt  = 2'b00;
    w_state_nxt = r_state;
    case (r_state)
      OCC_ONE:  w_grant = w_want;
      OCC_BOTH: w_grant = (&w_want) ? (r_old1 ? 2'b10 : 2'b01) : w_want;
      default:  w_grant = 2'b00;
    endcase
    for (int i = 0; i < 2; i++)
      w_held_nxt[i] = w_valid[i] | (w_held[i] & ~(w_grant[i] | w_zero[i]));
    case (w_held_nxt)
      2'b00:   w_state_nxt = OCC_EMPTY;
      2'b11:   w_state_nxt = OCC_BOTH;
      default: w_state_nxt = OCC_ONE;
    endcase
  end

  // r_old1: slot 1 holds the older entry; ties use rr unless both target the same register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_old1 <= 1'b0;
      r_rr   <= 1'b0;
    end else if (&w_accept) begin
      if (req0_addr == req1_addr) begin
        r_old1 <= 1'b0;
      end else begin
        r_old1 <= r_rr;
        r_rr   <= ~r_rr;
      end
    end else if (w_accept[0]) begin
      r_old1 <= 1'b1;
    end else if (w_accept[1]) begin
      r_old1 <= 1'b0;
    end
  end

  assign rf_we      = |w_grant;
  assign rf_waddr   = w_grant[1] ? w_entry1.addr : (w_grant[0] ? w_entry0.addr : ADDR_W'(0));
  assign rf_wdata   = w_grant[1] ? w_entry1.data : (w_grant[0] ? w_entry0.data : DATA_W'(0));
  assign req0_ready = w_ready[0];
  assign req1_ready = w_ready[1];
  assign busy       = w_held[0] & w_held[1] & ~w_drain[0] & ~w_drain[1];

`ifdef REGFILE_WB_BYPASS_EN
  function automatic logic [DATA_W-1:0] fwd(
    input logic [ADDR_W-1:0] raddr,
    input logic [DATA_W-1:0] rf_rdata,
    input logic [1:0]        held,
    input wb_req_t           e0,
    input wb_req_t           e1,
    input logic              old1
  );
    logic hit0;
    logic hit1;
    hit0 = held[0] & (e0.addr == raddr) & (raddr != REG_ZERO);
    hit1 = held[1] & (e1.addr == raddr) & (raddr != REG_ZERO);
    if (hit0 & hit1) return old1 ? e0.data : e1.data;
    else if (hit0)   return e0.data;
    else if (hit1)   return e1.data;
    else             return rf_rdata;
  endfunction

  assign rdata1 = fwd(raddr1, rf_rdata1, w_held, w_entry0, w_entry1, r_old1);
  assign rdata2 = fwd(raddr2, rf_rdata2, w_held, w_entry0, w_entry1, r_old1);
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a small regfile model on the write port.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy;
`ifdef REGFILE_WB_BYPASS_EN
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rf_rdata1, rf_rdata2, rdata1, rdata2;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int r0_writes = 0;
  logic [31:0] rf [32];

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
`ifdef REGFILE_WB_BYPASS_EN
    .raddr1     (raddr1),
    .raddr2     (raddr2),
    .rf_rdata1  (rf_rdata1),
    .rf_rdata2  (rf_rdata2),
    .rdata1     (rdata1),
    .rdata2     (rdata2),
`endif
    .busy       (busy)
  );

`ifdef REGFILE_WB_BYPASS_EN
  assign rf_rdata1 = rf[raddr1];
  assign rf_rdata2 = rf[raddr2];
`endif

  // Regfile model: writes on posedge, r0 stays zero
  always @(posedge clk) begin
    if (rf_we && rf_waddr != 5'd0) rf[rf_waddr] <= rf_wdata;
    if (rf_we && rf_waddr == 5'd0) r0_writes <= r0_writes + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [4:0] a, input logic [31:0] d);
    req0_valid = v; req0_addr = a; req0_data = d;
  endtask

  task automatic drive1(input logic v, input logic [4:0] a, input logic [31:0] d);
    req1_valid = v; req1_addr = a; req1_data = d;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive0(1'b0, 5'd0, 32'd0);
    drive1(1'b0, 5'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (rf_we !== 1'b0) $display("FAIL reset_we: got %b want 0", rf_we); else n_pass++;
    n_chk++; if (rf_waddr !== 5'd0) $display("FAIL reset_waddr: got %0d want 0", rf_waddr); else n_pass++;
    n_chk++; if (rf_wdata !== 32'd0) $display("FAIL reset_wdata: got %0d want 0", rf_wdata); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (req0_ready !== 1'b1) $display("FAIL reset_ready0: got %b want 1", req0_ready); else n_pass++;
    n_chk++; if (req1_ready !== 1'b1) $display("FAIL reset_ready1: got %b want 1", req1_ready); else n_pass++;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    drive0(1'b1, 5'd19, 32'd123456);
    #1;
    n_chk++; if (req0_ready !== 1'b1) $display("FAIL single_ready: got %b want 1", req0_ready); else n_pass++;
    tick();
    drive0(1'b0, 5'd0, 32'd0);
    #1;
    n_chk++; if (rf_we !== 1'b1) $display("FAIL single_we: got %b want 1", rf_we); else n_pass++;
    n_chk++; if (rf_waddr !== 5'd19) $display("FAIL single_waddr: got %0d want 19", rf_waddr); else n_pass++;
    n_chk++; if (rf_wdata !== 32'd123456) $display("FAIL single_wdata: got %0d want 123456", rf_wdata); else n_pass++;
    tick();
    n_chk++; if (rf_we !== 1'b0) $display("FAIL single_idle_we: got %b want 0", rf_we); else n_pass++;
    n_chk++; if (rf[19] !== 32'd123456) $display("FAIL single_r19: got %0d want 123456", rf[19]); else n_pass++;
  endtask

  // Two simultaneous requests; first/second are the expected write order
  task automatic pair_cycle(input string nm,
                            input logic [4:0] a0, input logic [31:0] d0,
                            input logic [4:0] a1, input logic [31:0] d1,
                            input logic [4:0] fa, input logic [31:0] fd,
                            input logic [4:0] sa, input logic [31:0] sd);
    drive0(1'b1, a0, d0);
    drive1(1'b1, a1, d1);
    tick();
    drive0(1'b0, 5'd0, 32'd0);
    drive1(1'b0, 5'd0, 32'd0);
    #1;
    n_chk++; if (rf_we !== 1'b1 || rf_waddr !== fa || rf_wdata !== fd)
      $display("FAIL %s_first: got we=%b r%0d=%0d want we=1 r%0d=%0d", nm, rf_we, rf_waddr, rf_wdata, fa, fd);
    else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL %s_busy: got %b want 0", nm, busy); else n_pass++;
    tick();
    n_chk++; if (rf_we !== 1'b1 || rf_waddr !== sa || rf_wdata !== sd)
      $display("FAIL %s_second: got we=%b r%0d=%0d want we=1 r%0d=%0d", nm, rf_we, rf_waddr, rf_wdata, sa, sd);
    else n_pass++;
    tick();
    n_chk++; if (rf_we !== 1'b0) $display("FAIL %s_idle: got %b want 0", nm, rf_we); else n_pass++;
  endtask

  task automatic test_conflict();
    drive0(1'b1, 5'd19, 32'd233);
    drive1(1'b1, 5'd23, 32'd654321);
    tick();
    drive0(1'b0, 5'd0, 32'd0);
    drive1(1'b0, 5'd0, 32'd0);
`ifdef REGFILE_WB_BYPASS_EN
    raddr1 = 5'd19;
    raddr2 = 5'd23;
`endif
    #1;
    n_chk++; if (rf_waddr !== 5'd19 || rf_wdata !== 32'd233)
      $display("FAIL conflict_first: got r%0d=%0d want r19=233", rf_waddr, rf_wdata); else n_pass++;
    n_chk++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
      $display("FAIL conflict_ready: got %b%b want 10", req0_ready, req1_ready); else n_pass++;
`ifdef REGFILE_WB_BYPASS_EN
    n_chk++; if (rdata1 !== 32'd233) $display("FAIL bypass_r19: got %0d want 233", rdata1); else n_pass++;
    n_chk++; if (rdata2 !== 32'd654321) $display("FAIL bypass_r23: got %0d want 654321", rdata2); else n_pass++;
`endif
    tick();
    n_chk++; if (rf_waddr !== 5'd23 || rf_wdata !== 32'd654321)
      $display("FAIL conflict_second: got r%0d=%0d want r23=654321", rf_waddr, rf_wdata); else n_pass++;
    tick();
    n_chk++; if (rf[19] !== 32'd233 || rf[23] !== 32'd654321)
      $display("FAIL conflict_rf: got r19=%0d r23=%0d want 233 654321", rf[19], rf[23]); else n_pass++;
    // rr toggled to 1: port 1 wins the next tie
    pair_cycle("rr_toggle", 5'd1, 32'd11, 5'd2, 32'd22, 5'd2, 32'd22, 5'd1, 32'd11);
  endtask

  // Tie goes to slot 0 (rr back at 0); refilling slot 0 makes slot 1 older, so port 0 backs up
  task automatic test_backpressure();
    drive0(1'b1, 5'd11, 32'd111);
    drive1(1'b1, 5'd12, 32'd120);
    tick();
    drive0(1'b1, 5'd13, 32'd130);
    drive1(1'b0, 5'd0, 32'd0);
    #1;
    n_chk++; if (rf_waddr !== 5'd11) $display("FAIL bp_first: got r%0d want r11", rf_waddr); else n_pass++;
    n_chk++; if (req0_ready !== 1'b1) $display("FAIL bp_refill_ready: got %b want 1", req0_ready); else n_pass++;
    tick();
    drive0(1'b1, 5'd14, 32'd140);
`ifdef REGFILE_WB_BYPASS_EN
    raddr1 = 5'd13;
    raddr2 = 5'd12;
`endif
    #1;
    n_chk++; if (rf_waddr !== 5'd12 || rf_wdata !== 32'd120)
      $display("FAIL bp_older: got r%0d=%0d want r12=120", rf_waddr, rf_wdata); else n_pass++;
    n_chk++; if (req0_ready !== 1'b0) $display("FAIL bp_stall: got %b want 0", req0_ready); else n_pass++;
    n_chk++; if (req1_ready !== 1'b1) $display("FAIL bp_ready1: got %b want 1", req1_ready); else n_pass++;
    // Both slots held, but the granted one is draining this cycle
    n_chk++; if (busy !== 1'b0) $display("FAIL bp_busy: got %b want 0", busy); else n_pass++;
`ifdef REGFILE_WB_BYPASS_EN
    n_chk++; if (rdata1 !== 32'd130) $display("FAIL bp_bypass1: got %0d want 130", rdata1); else n_pass++;
    n_chk++; if (rdata2 !== 32'd120) $display("FAIL bp_bypass2: got %0d want 120", rdata2); else n_pass++;
`endif
    tick();
    n_chk++; if (rf_waddr !== 5'd13 || req0_ready !== 1'b1)
      $display("FAIL bp_drain: got r%0d ready=%b want r13 ready=1", rf_waddr, req0_ready); else n_pass++;
    tick();
    drive0(1'b0, 5'd0, 32'd0);
    #1;
    n_chk++; if (rf_waddr !== 5'd14 || rf_wdata !== 32'd140)
      $display("FAIL bp_last: got r%0d=%0d want r14=140", rf_waddr, rf_wdata); else n_pass++;
    tick();
    n_chk++; if (rf[11] !== 32'd111 || rf[12] !== 32'd120 || rf[13] !== 32'd130 || rf[14] !== 32'd140)
      $display("FAIL bp_rf: got %0d %0d %0d %0d want 111 120 130 140", rf[11], rf[12], rf[13], rf[14]);
    else n_pass++;
  endtask

  task automatic test_same_addr();
    drive0(1'b1, 5'd5, 32'd1);
    tick();
    drive0(1'b0, 5'd0, 32'd0);
    drive1(1'b1, 5'd5, 32'd2);
    #1;
    n_chk++; if (rf_waddr !== 5'd5 || rf_wdata !== 32'd1)
      $display("FAIL same_first: got r%0d=%0d want r5=1", rf_waddr, rf_wdata); else n_pass++;
    tick();
    drive1(1'b0, 5'd0, 32'd0);
    #1;
    n_chk++; if (rf_waddr !== 5'd5 || rf_wdata !== 32'd2)
      $display("FAIL same_second: got r%0d=%0d want r5=2", rf_waddr, rf_wdata); else n_pass++;
    tick();
    n_chk++; if (rf[5] !== 32'd2) $display("FAIL same_final: got %0d want 2", rf[5]); else n_pass++;
    // rr is 1 here, yet the same-address tie must still grant port 0 first
    pair_cycle("same_tie", 5'd9, 32'hA, 5'd9, 32'hB, 5'd9, 32'hA, 5'd9, 32'hB);
    n_chk++; if (rf[9] !== 32'hB) $display("FAIL same_tie_final: got %0h want b", rf[9]); else n_pass++;
  endtask

  task automatic test_r0_drop();
    drive1(1'b1, 5'd0, 32'd777);
    tick();
    drive1(1'b0, 5'd0, 32'd0);
    #1;
    n_chk++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0)
      $display("FAIL r0_we: got we=%b r%0d=%0d want we=0 r0=0", rf_we, rf_waddr, rf_wdata); else n_pass++;
    n_chk++; if (req1_ready !== 1'b1) $display("FAIL r0_ready: got %b want 1", req1_ready); else n_pass++;
    tick();
    n_chk++; if (rf_we !== 1'b0) $display("FAIL r0_after: got %b want 0", rf_we); else n_pass++;
    n_chk++; if (r0_writes !== 0 || rf[0] !== 32'd0)
      $display("FAIL r0_rf: got writes=%0d r0=%0d want 0 0", r0_writes, rf[0]); else n_pass++;
  endtask

  task automatic test_reset_mid();
    drive0(1'b1, 5'd20, 32'd55);
    drive1(1'b1, 5'd21, 32'd66);
    tick();
    drive0(1'b0, 5'd0, 32'd0);
    drive1(1'b0, 5'd0, 32'd0);
    rst = 1'b0;
    #1;
    n_chk++; if (rf_we !== 1'b0 || busy !== 1'b0)
      $display("FAIL rstmid_out: got we=%b busy=%b want 0 0", rf_we, busy); else n_pass++;
    n_chk++; if (req0_ready !== 1'b1 || req1_ready !== 1'b1)
      $display("FAIL rstmid_ready: got %b%b want 11", req0_ready, req1_ready); else n_pass++;
    tick();
    rst = 1'b1;
    tick();
    tick();
    n_chk++; if (rf_we !== 1'b0) $display("FAIL rstmid_idle: got %b want 0", rf_we); else n_pass++;
    n_chk++; if (rf[20] !== 32'd0 || rf[21] !== 32'd0)
      $display("FAIL rstmid_rf: got r20=%0d r21=%0d want 0 0", rf[20], rf[21]); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
`ifdef REGFILE_WB_BYPASS_EN
    raddr1 = 5'd0;
    raddr2 = 5'd0;
`endif
    test_reset();
    test_single();
    test_conflict();
    test_backpressure();
    test_same_addr();
    test_r0_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
